fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Packet-level arbiter sharing the single write port of the I2C async FIFO between two requesters, e.g. the master TX data path and the register/command path. It grants the port to one requester at a time and holds the grant until that requester's packet ends, so packets never interleave in the FIFO. It does not start a packet when the FIFO is almost full, and it stalls transfers while the FIFO is full. It sits in the FIFO write clock domain, directly in front of the write-pointer/full-flag logic.

## Interface
- data_size, 8, width of FIFO data word
- count_size, 4, width of internal packet word counter
- max_packet, 8, maximum words per grant; must be ≤ 2**count_size − 1
- write_clock_i  in  1  FIFO write-domain clock
- write_reset_i  in  1  asynchronous, active-high reset
- req0_valid_i  in  1  requester 0 has a word
- req0_data_i  in  data_size  requester 0 word
- req0_last_i  in  1  word is last of requester 0 packet
- req0_ready_o  out  1  requester 0 word accepted this cycle when valid
- req1_valid_i, req1_data_i, req1_last_i, req1_ready_o  same as requester 0
- write_full_i  in  1  FIFO full flag, write domain
- write_almost_full_i  in  1  FIFO almost-full flag, write domain
- write_inc_o  out  1  FIFO write strobe
- write_data_o  out  data_size  FIFO write data
- grant_o  out  2  one-hot current owner; 00 when idle
- overflow_o  out  1  sticky: a packet exceeded max_packet
- clear_overflow_i  in  1  synchronous clear of overflow_o

## Operation
- FSM states are IDLE and BUSY. Registers: state, owner (1 bit), last_owner (1 bit), word_cnt (count_size bits), overflow_o.
- **IDLE:**
  - Start a packet only when write_full_i = 0 and write_almost_full_i = 0.
  - If exactly one requester is valid, that requester wins.
  - If both are valid, the requester ≠ last_owner wins (round-robin).
  - On a win: state → BUSY, owner ← winner, word_cnt ← 0.
  - No word is transferred in IDLE. Both ready outputs are 0.
- **BUSY:**
  - reqN_ready_o = (owner == N) & ~write_full_i. The non-owner's ready is 0.
  - Transfer = owner valid & owner ready. write_inc_o = transfer. write_data_o = owner data (the mux follows owner even when no transfer occurs).
  - On a transfer with last = 1: state → IDLE, last_owner ← owner.
  - On a transfer with last = 0 and word_cnt == max_packet − 1: forced release. State → IDLE, last_owner ← owner, overflow_o ← 1. The requester's next word arbitrates as a new packet.
  - Otherwise, on a transfer: word_cnt ← word_cnt + 1. The counter never wraps because release occurs first.
  - If the owner drops valid, the grant is held; the arbiter waits indefinitely.
- write_almost_full_i affects only the start of a packet. An in-progress packet continues until write_full_i.
- overflow_o:
  - clear_overflow_i clears it.
  - If a set and clear_overflow_i occur in the same cycle, set wins.

## Timing
- Reset (asynchronous, active-high):
  - state = IDLE, owner = 0, last_owner = 1 (requester 0 wins the first tie), word_cnt = 0, overflow_o = 0.
  - Outputs: write_inc_o = 0, ready outputs = 0, grant_o = 00, write_data_o = 0.
  - Reset asserted mid-packet kills the write strobe immediately (asynchronously). The partial packet is left in the FIFO.
- grant_o, ready, write_inc_o and write_data_o are combinational from registered state/owner, the request inputs and write_full_i. No extra pipeline stage.
- Arbitration latency:
  - Valid asserted in cycle t while idle: grant visible in t+1, first transfer at the t+1 edge at the earliest.
  - Packet throughput: one idle cycle between packets, then one word per cycle.
- write_full_i reflects the FIFO's registered full flag, already updated for the write at the previous edge, so a write is never issued into a full FIFO.
- last on the same cycle as the forced-release count: treated as a normal end, overflow_o not set.
- Simultaneous valid arriving at IDLE with write_almost_full_i = 1: no grant until almost-full deasserts.

## Test plan
- **Reset:** assert write_reset_i mid-BUSY with req0 streaming → write_inc_o = 0 and grant_o = 00 in the same cycle. After release, req0 and req1 both valid → grant_o = 01.
- **Round-robin:** req0 and req1 each continuously send 3-word packets (last on the 3rd word) → FIFO receives A0 A1 A2 B0 B1 B2 A0 A1 A2 …, with one idle cycle between packets and no interleaving.
- **Full stall:** req1 owner, write_full_i = 1 for 4 cycles mid-packet → req1_ready_o = 0 and write_inc_o = 0 for those 4 cycles; the held word is written the cycle full drops, with no loss or duplicate.
- **Almost-full gate:** write_almost_full_i = 1 in IDLE with req0 valid → no grant. Deassert → grant_o = 01 next cycle. Almost-full rising mid-packet → packet continues.
- **Overflow:** max_packet = 8, req0 sends 10 words with last on word 10 → grant drops after word 8, overflow_o = 1, and words 9–10 are sent as a new grant after the idle cycle. clear_overflow_i pulse → overflow_o = 0.
- **Owner bubble:** req0 owner drops valid for 5 cycles while req1 is valid → grant_o stays 01, req1_ready_o = 0, and req0 resumes without re-arbitration.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Packet-level arbiter sharing the async FIFO write port between two requesters.
// Grants are held for a whole packet (or max_packet words) so packets never interleave.
module fifo_write_arbiter #(
    parameter int unsigned data_size  = 8,
    parameter int unsigned count_size = 4,
    parameter int unsigned max_packet = 8
) (
    input  logic                 write_clock_i,
    input  logic                 write_reset_i,
    input  logic                 req0_valid_i,
    input  logic [data_size-1:0] req0_data_i,
    input  logic                 req0_last_i,
    output logic                 req0_ready_o,
    input  logic                 req1_valid_i,
    input  logic [data_size-1:0] req1_data_i,
    input  logic                 req1_last_i,
    output logic                 req1_ready_o,
    input  logic                 write_full_i,
    input  logic                 write_almost_full_i,
    output logic                 write_inc_o,
    output logic [data_size-1:0] write_data_o,
    output logic [1:0]           grant_o,
    output logic                 overflow_o,
    input  logic                 clear_overflow_i
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [count_size-1:0] last_count = count_size'(max_packet - 1);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic [count_size-1:0] word_cnt_q, word_cnt_d;
    logic                  overflow_d;
    logic                  owner_valid;
    logic                  owner_last;
    logic                  transfer;

    // State register; reset makes requester 0 win the first tie.
    always_ff @(posedge write_clock_i or posedge write_reset_i) begin
        if (write_reset_i) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            word_cnt_q   <= '0;
            overflow_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            word_cnt_q   <= word_cnt_d;
            overflow_o   <= overflow_d;
        end
    end

    // Arbitration, handshake and packet tracking.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        word_cnt_d   = word_cnt_q;
        overflow_d   = overflow_o & ~clear_overflow_i;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        write_inc_o  = 1'b0;
        write_data_o = '0;
        grant_o      = 2'b00;
        owner_valid  = owner_q ? req1_valid_i : req0_valid_i;
        owner_last   = owner_q ? req1_last_i  : req0_last_i;
        transfer     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!write_full_i && !write_almost_full_i &&
                    (req0_valid_i || req1_valid_i)) begin
                    state_d    = BUSY;
                    word_cnt_d = '0;
                    if (req0_valid_i && req1_valid_i) begin
                        owner_d = ~last_owner_q;
                    end else begin
                        owner_d = req1_valid_i;
                    end
                end
            end
            BUSY: begin
                grant_o      = owner_q ? 2'b10 : 2'b01;
                req0_ready_o = ~owner_q & ~write_full_i;
                req1_ready_o = owner_q & ~write_full_i;
                write_data_o = owner_q ? req1_data_i : req0_data_i;
                transfer     = owner_valid & ~write_full_i;
                write_inc_o  = transfer;
                if (transfer) begin
                    if (owner_last) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end else if (word_cnt_q == last_count) begin
                        // Oversized packet: release so the other side can get in.
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                        overflow_d   = 1'b1;
                    end else begin
                        word_cnt_d = word_cnt_q + count_size'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a packet-rule reference model.
module tb_fifo_write_arbiter;

    localparam int unsigned DW   = 8;
    localparam int unsigned CW   = 4;
    localparam int unsigned MAXP = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          vq [2];
    logic [DW-1:0] dq [2];
    logic          lq [2];
    logic          full, af, clr;
    logic          r0, r1, inc, ovf;
    logic [DW-1:0] wd;
    logic [1:0]    gnt;

    fifo_write_arbiter #(.data_size(DW), .count_size(CW), .max_packet(MAXP)) dut (
        .write_clock_i      (clk),
        .write_reset_i      (rst),
        .req0_valid_i       (vq[0]),
        .req0_data_i        (dq[0]),
        .req0_last_i        (lq[0]),
        .req0_ready_o       (r0),
        .req1_valid_i       (vq[1]),
        .req1_data_i        (dq[1]),
        .req1_last_i        (lq[1]),
        .req1_ready_o       (r1),
        .write_full_i       (full),
        .write_almost_full_i(af),
        .write_inc_o        (inc),
        .write_data_o       (wd),
        .grant_o            (gnt),
        .overflow_o         (ovf),
        .clear_overflow_i   (clr)
    );

    always #5 clk = ~clk;

    // Reference model: who holds the port and how many words it has written.
    bit  m_busy;
    int  m_owner, m_last, m_words;
    bit  m_ovf;
    bit  m_x [2];

    // Requester packet generators.
    int           idx [2];
    int           len [2];
    logic [DW-1:0] base [2];
    bit           rand_mode;

    logic [DW-1:0] wr_log [$];
    logic [DW-1:0] exp_q  [$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_last = 1; m_words = 0; m_ovf = 1'b0;
        m_x[0] = 1'b0; m_x[1] = 1'b0;
    endtask

    // One clock: compare outputs at negedge, advance model at posedge, return 1 time unit later.
    task automatic step();
        logic [1:0] eg;
        logic       ei;
        bit         set_ovf;
        @(negedge clk);
        eg = !m_busy ? 2'b00 : (m_owner == 1 ? 2'b10 : 2'b01);
        ei = m_busy && vq[m_owner] && !full;
        check("grant", 32'(gnt), 32'(eg));
        check("ready0", 32'(r0), 32'(m_busy && m_owner == 0 && !full));
        check("ready1", 32'(r1), 32'(m_busy && m_owner == 1 && !full));
        check("write_inc", 32'(inc), 32'(ei));
        check("overflow", 32'(ovf), 32'(m_ovf));
        if (ei) check("write_data", 32'(wd), 32'(dq[m_owner]));
        if (inc === 1'b1) wr_log.push_back(wd);
        @(posedge clk);
        m_x[0] = 1'b0; m_x[1] = 1'b0;
        set_ovf = 1'b0;
        if (!m_busy) begin
            if (!full && !af && (vq[0] || vq[1])) begin
                m_owner = (vq[0] && vq[1]) ? 1 - m_last : (vq[0] ? 0 : 1);
                m_busy  = 1'b1;
                m_words = 0;
            end
        end else if (vq[m_owner] && !full) begin
            m_x[m_owner] = 1'b1;
            m_words++;
            if (lq[m_owner]) begin
                m_busy = 1'b0; m_last = m_owner;
            end else if (m_words == MAXP) begin
                m_busy = 1'b0; m_last = m_owner; set_ovf = 1'b1;
            end
        end
        m_ovf = set_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
        #1;
    endtask

    // Present the next word of each requester after an accepted transfer.
    task automatic drive();
        for (int n = 0; n < 2; n++) begin
            if (m_x[n]) begin
                idx[n]++;
                if (idx[n] == len[n]) begin
                    idx[n] = 0;
                    if (rand_mode) begin
                        len[n]  = $urandom_range(1, 11);
                        base[n] = DW'($urandom);
                    end
                end
            end
            dq[n] = base[n] + DW'(idx[n]);
            lq[n] = (idx[n] == len[n] - 1);
        end
    endtask

    task automatic setup(input int n, input logic [DW-1:0] b, input int l);
        idx[n] = 0; len[n] = l; base[n] = b;
        dq[n] = b; lq[n] = (l == 1);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 32'(wr_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
            check(tag, 32'(wr_log[i]), 32'(exp_q[i]));
        wr_log.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1; full = 1'b0; af = 1'b0; clr = 1'b0; rand_mode = 1'b0;
        vq[0] = 1'b0; vq[1] = 1'b0;
        setup(0, 8'h00, 1); setup(1, 8'h00, 1);
        model_reset();
        @(negedge clk);
        check("rst_grant", 32'(gnt), 32'd0);
        check("rst_inc", 32'(inc), 32'd0);
        check("rst_ready0", 32'(r0), 32'd0);
        check("rst_ready1", 32'(r1), 32'd0);
        check("rst_data", 32'(wd), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset mid-packet kills the strobe at once; first tie then goes to requester 0.
        setup(0, 8'h10, 15); vq[0] = 1'b1;
        repeat (3) begin step(); drive(); end
        rst = 1'b1; #1;
        check("async_rst_inc", 32'(inc), 32'd0);
        check("async_rst_grant", 32'(gnt), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        setup(0, 8'h20, 1); setup(1, 8'h30, 1); vq[0] = 1'b1; vq[1] = 1'b1;
        step(); drive();
        check("first_tie", 32'(gnt), 32'b01);
        step(); drive();
        step(); drive();
        check("rr_second", 32'(gnt), 32'b10);
        step(); drive();
        vq[0] = 1'b0; vq[1] = 1'b0;
        step();
        wr_log.delete();

        // Round-robin with continuous 3-word packets.
        setup(0, 8'hA0, 3); setup(1, 8'hB0, 3); vq[0] = 1'b1; vq[1] = 1'b1;
        repeat (16) begin step(); drive(); end
        vq[0] = 1'b0; vq[1] = 1'b0;
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 3; i++) exp_q.push_back((p % 2 == 1 ? 8'hB0 : 8'hA0) + DW'(i));
        check_log("round_robin");

        // Full stall in the middle of a requester 1 packet.
        setup(1, 8'hC0, 4); vq[1] = 1'b1;
        repeat (3) begin step(); drive(); end
        full = 1'b1;
        repeat (4) begin
            step(); drive();
            check("stall_ready1", 32'(r1), 32'd0);
            check("stall_inc", 32'(inc), 32'd0);
        end
        full = 1'b0;
        repeat (2) begin step(); drive(); end
        vq[1] = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hC0 + DW'(i));
        check_log("full_stall");

        // Almost-full gates only packet start.
        setup(0, 8'hD0, 2); af = 1'b1; vq[0] = 1'b1;
        repeat (3) begin step(); drive(); check("af_no_grant", 32'(gnt), 32'd0); end
        af = 1'b0;
        step(); drive();
        check("af_grant", 32'(gnt), 32'b01);
        step(); drive();
        af = 1'b1;
        step(); drive();
        vq[0] = 1'b0; af = 1'b0;
        exp_q.push_back(8'hD0); exp_q.push_back(8'hD1);
        check_log("af_midpacket");

        // Oversized packet: forced release after max_packet words.
        setup(0, 8'h50, 10); vq[0] = 1'b1;
        check("ovf_before", 32'(ovf), 32'd0);
        n = 0;
        while (wr_log.size() < 10 && n < 40) begin step(); drive(); n++; end
        vq[0] = 1'b0;
        check("ovf_cycles", 32'(n), 32'd12);
        check("ovf_set", 32'(ovf), 32'd1);
        for (int i = 0; i < 10; i++) exp_q.push_back(8'h50 + DW'(i));
        check_log("overflow_words");
        clr = 1'b1; step(); clr = 1'b0;
        check("ovf_clear", 32'(ovf), 32'd0);

        // Last on the forced-release count is a normal end.
        setup(0, 8'h80, 8); vq[0] = 1'b1;
        n = 0;
        while (wr_log.size() < 8 && n < 40) begin step(); drive(); n++; end
        vq[0] = 1'b0;
        step();
        check("exact_max_no_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h80 + DW'(i));
        check_log("exact_max");

        // Owner drops valid: grant held, other requester blocked.
        setup(0, 8'h60, 4); setup(1, 8'h70, 1); vq[0] = 1'b1; vq[1] = 1'b0;
        repeat (2) begin step(); drive(); end
        vq[0] = 1'b0; vq[1] = 1'b1;
        repeat (5) begin
            step(); drive();
            check("bubble_grant", 32'(gnt), 32'b01);
            check("bubble_ready1", 32'(r1), 32'd0);
        end
        vq[0] = 1'b1;
        n = 0;
        while (wr_log.size() < 5 && n < 20) begin step(); drive(); n++; end
        vq[0] = 1'b0; vq[1] = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h60 + DW'(i));
        exp_q.push_back(8'h70);
        check_log("bubble");

        // Randomized traffic against the model.
        rand_mode = 1'b1;
        setup(0, DW'($urandom), $urandom_range(1, 11));
        setup(1, DW'($urandom), $urandom_range(1, 11));
        repeat (3000) begin
            vq[0] = ($urandom_range(0, 3) != 0);
            vq[1] = ($urandom_range(0, 3) != 0);
            full  = ($urandom_range(0, 4) == 0);
            af    = ($urandom_range(0, 4) == 0);
            clr   = ($urandom_range(0, 19) == 0);
            step(); drive();
        end
        wr_log.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
